// File: rtl/wb_master_interface.sv
// Wishbone pipelined bus master.
// Converts a single-outstanding request/response handshake into one Wishbone
// transaction at a time. All bus outputs are registered, a saturating counter
// bounds how long cyc may stay high, and bus errors/timeouts are returned
// in-band on the response.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no transaction; req_ready high, next request latched here
// S_REQUEST  | cyc/stb high, payload held until the slave drops stall
// S_WAIT_ACK | cyc high, stb low, waiting for ack or error
module wb_master_interface #(
    parameter int ADDR_WIDTH     = 24,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [3:0]            req_sel,
    input  logic [31:0]           req_data,
    output logic                  rsp_valid,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic [31:0]           rsp_data,
    output logic                  busy,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_data_o,
    input  logic                  wb_stall_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_error_i,
    input  logic [31:0]           wb_data_i
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REQUEST  = 2'd1;
    localparam logic [1:0] S_WAIT_ACK = 2'd2;

    // A zero timeout disables the watchdog; keep a 1-bit counter so the
    // declarations stay legal.
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]            r_state;
    logic                  r_cyc;
    logic                  r_stb;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [3:0]            r_sel;
    logic [31:0]           r_dat;
    logic [CNT_W-1:0]      r_to_cnt;
    logic                  r_rsp_valid;
    logic                  r_rsp_error;
    logic                  r_rsp_timeout;
    logic [31:0]           r_rsp_data;

    logic w_idle;
    logic w_in_flight;
    logic w_accept_req;
    logic w_bus_resp;
    logic w_timeout;
    logic w_done;

    assign w_idle       = (r_state == S_IDLE);
    assign w_in_flight  = !w_idle;
    assign w_accept_req = w_idle && req_valid;

    // ack/error count only once the slave has accepted the strobe; anything
    // seen while idle or while stalled is a protocol violation and dropped.
    assign w_bus_resp = (((r_state == S_REQUEST) && !wb_stall_i) || (r_state == S_WAIT_ACK))
                        && (wb_ack_i || wb_error_i);

    // A real response in the same cycle as the last allowed one wins.
    assign w_timeout = TO_EN && w_in_flight && !w_bus_resp && (r_to_cnt == TO_LAST);
    assign w_done    = w_bus_resp || w_timeout;

    // Transaction sequencing and registered bus payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_sel   <= '0;
            r_dat   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_adr   <= req_address;
                        r_sel   <= req_sel;
                        r_dat   <= req_data;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_state <= S_REQUEST;
                    end
                end
                S_REQUEST: begin
                    if (w_done) begin
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (!wb_stall_i) begin
                        r_stb   <= 1'b0;
                        r_state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (w_done) begin
                        r_cyc   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Watchdog: counts cycles with cyc high and no response, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_accept_req) begin
            r_to_cnt <= '0;
        end else if (w_in_flight && !w_bus_resp && (r_to_cnt != CNT_MAX)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Response capture; fields are qualified by the one-cycle rsp_valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_data    <= '0;
        end else begin
            r_rsp_valid <= w_done;
            if (w_bus_resp) begin
                r_rsp_timeout <= 1'b0;
                if (wb_error_i) begin
                    r_rsp_error <= 1'b1;
                    r_rsp_data  <= 32'hFFFF_FFFF;
                end else begin
                    r_rsp_error <= 1'b0;
                    r_rsp_data  <= wb_data_i;
                end
            end else if (w_timeout) begin
                r_rsp_error   <= 1'b1;
                r_rsp_timeout <= 1'b1;
                r_rsp_data    <= 32'hFFFF_FFFF;
            end
        end
    end

    assign req_ready   = w_idle;
    assign busy        = w_in_flight;
    assign wb_cyc_o    = r_cyc;
    assign wb_stb_o    = r_stb;
    assign wb_we_o     = r_we;
    assign wb_adr_o    = r_adr;
    assign wb_sel_o    = r_sel;
    assign wb_data_o   = r_dat;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_error   = r_rsp_error;
    assign rsp_timeout = r_rsp_timeout;
    assign rsp_data    = r_rsp_data;

endmodule
